// File: rtl/serial_word_if.sv
// Handshake and serial-output bundle between an upstream word source and serial_word_tx.
// The master side supplies words and the bit-rate strobe; the slave side produces the serial stream.
interface serial_word_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] in_data;
   logic             in_valid;
   logic             in_ready;
   logic             bit_en;
   logic             d_out;
   logic             d_valid;
   logic             d_last;
   logic             busy;

   modport master (
      output in_data, in_valid, bit_en,
      input  in_ready, d_out, d_valid, d_last, busy
   );

   modport slave (
      input  in_data, in_valid, bit_en,
      output in_ready, d_out, d_valid, d_last, busy
   );
endinterface

// File: rtl/serial_word_tx.sv
// Double-buffered parallel-to-serial word transmitter: one bit per bit_en strobe, gap-free framing.
// Define SER_PARITY_EN to append an even-parity bit to every frame (frame becomes WIDTH+1 bits).
module serial_word_tx #(
   parameter int   WIDTH      = 8,
   parameter bit   LSB_FIRST  = 1'b0,
   parameter logic IDLE_LEVEL = 1'b0
) (
   input  logic         clk,
   input  logic         reset,
   serial_word_if.slave bus
);
   localparam int CW = $clog2(WIDTH + 1);
   localparam int IW = $clog2(WIDTH);

`ifdef SER_PARITY_EN
   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_PAR} state_t;
`else
   typedef enum logic [0:0] {S_IDLE, S_SHIFT} state_t;
`endif

   state_t           r_state;
   logic [WIDTH-1:0] r_hold;
   logic             r_hold_full;
   logic [WIDTH-1:0] r_shift;
   logic [CW-1:0]    r_cnt;
   logic             r_d_out;
   logic             r_d_valid;
   logic             r_d_last;

   logic [IW-1:0]    w_idx;
   logic             w_first_bit;
   logic             w_next_bit;
   logic             w_frame_done;

   // r_cnt bits of the word are already on the line; w_idx picks the one that goes next.
   always_comb begin
      if (LSB_FIRST) begin
         w_idx = IW'(r_cnt);
      end else begin
         w_idx = IW'(CW'(WIDTH - 1) - r_cnt);
      end
   end

   assign w_next_bit  = r_shift[w_idx];
   assign w_first_bit = LSB_FIRST ? r_hold[0] : r_hold[WIDTH-1];

`ifdef SER_PARITY_EN
   assign w_frame_done = (r_state == S_PAR);
`else
   assign w_frame_done = (r_state == S_SHIFT) && (r_cnt == CW'(WIDTH));
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= S_IDLE;
         r_hold      <= '0;
         r_hold_full <= 1'b0;
         r_shift     <= '0;
         r_cnt       <= '0;
         r_d_out     <= IDLE_LEVEL;
         r_d_valid   <= 1'b0;
         r_d_last    <= 1'b0;
      end else begin
         // Capture and hold-to-shifter transfer are mutually exclusive via r_hold_full.
         if (bus.in_valid && !r_hold_full) begin
            r_hold      <= bus.in_data;
            r_hold_full <= 1'b1;
         end

         if (bus.bit_en) begin
            if ((r_state == S_IDLE) || w_frame_done) begin
               if (r_hold_full) begin
                  r_shift     <= r_hold;
                  r_hold_full <= 1'b0;
                  r_d_out     <= w_first_bit;
                  r_d_valid   <= 1'b1;
                  r_d_last    <= 1'b0;
                  r_cnt       <= CW'(1);
                  r_state     <= S_SHIFT;
               end else begin
                  r_state     <= S_IDLE;
                  r_d_out     <= IDLE_LEVEL;
                  r_d_valid   <= 1'b0;
                  r_d_last    <= 1'b0;
                  r_cnt       <= '0;
               end
            end else if (r_cnt != CW'(WIDTH)) begin
               r_d_out   <= w_next_bit;
               r_d_valid <= 1'b1;
               r_cnt     <= r_cnt + CW'(1);
`ifdef SER_PARITY_EN
               r_d_last  <= 1'b0;
`else
               r_d_last  <= (r_cnt == CW'(WIDTH - 1));
`endif
            end
`ifdef SER_PARITY_EN
            else begin
               // Even parity over the whole word; the shifter is not disturbed while sending data.
               r_state   <= S_PAR;
               r_d_out   <= ^r_shift;
               r_d_valid <= 1'b1;
               r_d_last  <= 1'b1;
            end
`endif
         end
      end
   end

   assign bus.in_ready = ~r_hold_full;
   assign bus.d_out    = r_d_out;
   assign bus.d_valid  = r_d_valid;
   assign bus.d_last   = r_d_last;
   assign bus.busy     = (r_state != S_IDLE) | r_hold_full;

endmodule

// File: tb/tb_serial_word_tx.sv
// Directed, table-driven bench for serial_word_tx: MSB-first at full rate and LSB-first at 1/3 rate.
// Expected bit sequences and parity are hand-computed in the vector table.
module tb_serial_word_tx;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   serial_word_if #(.WIDTH(8)) if_a ();
   serial_word_if #(.WIDTH(8)) if_b ();

   serial_word_tx #(.WIDTH(8), .LSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u_dut_a (
      .clk   (clk),
      .reset (reset),
      .bus   (if_a.slave)
   );

   serial_word_tx #(.WIDTH(8), .LSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_dut_b (
      .clk   (clk),
      .reset (reset),
      .bus   (if_b.slave)
   );

`ifdef SER_PARITY_EN
   localparam int FB = 9;
`else
   localparam int FB = 8;
`endif

   // msb_seq / lsb_seq: bits in transmit order, element [7] goes out first.
   typedef struct {
      logic [7:0] word;
      logic [7:0] msb_seq;
      logic [7:0] lsb_seq;
      logic       par;
   } vec_t;

   typedef struct {
      int   cyc;
      logic d;
      logic last;
      logic rdy;
   } smp_t;

   vec_t       vecs [8];
   smp_t       rxa [$];
   smp_t       rxb [$];
   logic [7:0] txa [$];
   logic [7:0] txb [$];

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int b_ph   = 0;
   int stall_a = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic logic exp_bit(input vec_t v, input bit lsb, input int k);
      if (k >= 8) return v.par;
      return lsb ? v.lsb_seq[7-k] : v.msb_seq[7-k];
   endfunction

   // Called at a negedge: drive inputs, run one clock, sample at the following negedge.
   task automatic step();
      logic ra, rb;
      ra = if_a.in_ready;
      rb = if_b.in_ready;
      if_a.in_valid = (txa.size() > 0);
      if_a.in_data  = (txa.size() > 0) ? txa[0] : 8'h00;
      if_a.bit_en   = 1'b1;
      if_b.in_valid = (txb.size() > 0);
      if_b.in_data  = (txb.size() > 0) ? txb[0] : 8'h00;
      if_b.bit_en   = (b_ph == 0);
      b_ph = (b_ph + 1) % 3;
      @(negedge clk);
      cyc++;
      if (if_a.in_valid && ra) txa.delete(0);
      if (if_a.in_valid && !ra) stall_a++;
      if (if_b.in_valid && rb) txb.delete(0);
      if (if_a.d_valid) rxa.push_back('{cyc, if_a.d_out, if_a.d_last, if_a.in_ready});
      if (if_b.d_valid) rxb.push_back('{cyc, if_b.d_out, if_b.d_last, if_b.in_ready});
   endtask

   task automatic stream_a(input int i0, input int i1, input int i2, input int n, input int exp_stall);
      int idx[3];
      int t0;
      idx = '{i0, i1, i2};
      rxa.delete();
      stall_a = 0;
      for (int w = 0; w < n; w++) txa.push_back(vecs[idx[w]].word);
      t0 = cyc;
      repeat (n * FB + FB + 4) step();
      chk("stream_len", 32'(rxa.size()), 32'(n * FB));
      chk("stream_stalls", 32'(stall_a), 32'(exp_stall));
      for (int k = 0; k < n * FB && k < rxa.size(); k++) begin
         chk($sformatf("stream_bit%0d", k), 32'(rxa[k].d), 32'(exp_bit(vecs[idx[k / FB]], 1'b0, k % FB)));
         chk($sformatf("stream_last%0d", k), 32'(rxa[k].last), 32'((k % FB) == FB - 1));
         chk($sformatf("stream_cyc%0d", k), 32'(rxa[k].cyc), 32'(t0 + 2 + k));
      end
      chk("stream_idle", 32'(if_a.d_valid), 32'(0));
      $display("A stream of %0d words: samples=%0d stalls=%0d", n, rxa.size(), stall_a);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      vecs[0] = '{8'hB4, 8'b10110100, 8'b00101101, 1'b0};
      vecs[1] = '{8'h55, 8'b01010101, 8'b10101010, 1'b0};
      vecs[2] = '{8'hAA, 8'b10101010, 8'b01010101, 1'b0};
      vecs[3] = '{8'h07, 8'b00000111, 8'b11100000, 1'b1};
      vecs[4] = '{8'h03, 8'b00000011, 8'b11000000, 1'b0};
      vecs[5] = '{8'h01, 8'b00000001, 8'b10000000, 1'b1};
      vecs[6] = '{8'h80, 8'b10000000, 8'b00000001, 1'b1};
      vecs[7] = '{8'hFF, 8'b11111111, 8'b11111111, 1'b0};

      reset = 1'b0;
      if_a.in_valid = 1'b0; if_a.in_data = 8'h00; if_a.bit_en = 1'b1;
      if_b.in_valid = 1'b0; if_b.in_data = 8'h00; if_b.bit_en = 1'b0;
      #12;
      chk("rst_a_dout",  32'(if_a.d_out),    32'(0));
      chk("rst_a_valid", 32'(if_a.d_valid),  32'(0));
      chk("rst_a_last",  32'(if_a.d_last),   32'(0));
      chk("rst_a_ready", 32'(if_a.in_ready), 32'(1));
      chk("rst_a_busy",  32'(if_a.busy),     32'(0));
      chk("rst_b_ready", 32'(if_b.in_ready), 32'(1));
      chk("rst_b_busy",  32'(if_b.busy),     32'(0));
      @(negedge clk);
      reset = 1'b1;
      repeat (5) step();
      chk("idle_quiet_a", 32'(rxa.size()), 32'(0));
      chk("idle_quiet_b", 32'(rxb.size()), 32'(0));
      $display("reset and idle phase complete");

      // Single words at full rate, one table entry per transaction.
      for (int i = 0; i < 8; i++) begin
         int t0;
         rxa.delete();
         txa.push_back(vecs[i].word);
         step();
         chk("ready_drop", 32'(if_a.in_ready), 32'(0));
         chk("busy_held",  32'(if_a.busy),     32'(1));
         chk("no_bit_yet", 32'(if_a.d_valid),  32'(0));
         t0 = cyc;
         repeat (FB + 2) step();
         chk("frame_len", 32'(rxa.size()), 32'(FB));
         for (int k = 0; k < FB && k < rxa.size(); k++) begin
            chk($sformatf("v%0d_bit%0d", i, k),  32'(rxa[k].d),    32'(exp_bit(vecs[i], 1'b0, k)));
            chk($sformatf("v%0d_last%0d", i, k), 32'(rxa[k].last), 32'(k == FB - 1));
            chk($sformatf("v%0d_cyc%0d", i, k),  32'(rxa[k].cyc),  32'(t0 + 1 + k));
         end
         if (rxa.size() > 0) chk("ready_after_load", 32'(rxa[0].rdy), 32'(1));
         chk("end_valid", 32'(if_a.d_valid), 32'(0));
         chk("end_dout",  32'(if_a.d_out),   32'(0));
         chk("end_busy",  32'(if_a.busy),    32'(0));
         $display("A vec %0d word=%h samples=%0d", i, vecs[i].word, rxa.size());
      end

      // Back-to-back and deep backpressure on the full-rate instance.
      stream_a(1, 2, 0, 2, 1);
      stream_a(3, 4, 7, 3, FB);

      // LSB-first instance, one bit per three cycles.
      for (int j = 0; j < 2; j++) begin
         int vi;
         vi = (j == 0) ? 5 : 0;
         rxb.delete();
         txb.push_back(vecs[vi].word);
         step();
         chk("b_ready_drop", 32'(if_b.in_ready), 32'(0));
         repeat (3 * FB + 6) step();
         chk("b_samples", 32'(rxb.size()), 32'(3 * FB));
         for (int s = 0; s < 3 * FB && s < rxb.size(); s++) begin
            chk($sformatf("b%0d_bit%0d", j, s),  32'(rxb[s].d),    32'(exp_bit(vecs[vi], 1'b1, s / 3)));
            chk($sformatf("b%0d_last%0d", j, s), 32'(rxb[s].last), 32'((s / 3) == FB - 1));
            chk($sformatf("b%0d_cyc%0d", j, s),  32'(rxb[s].cyc),  32'(rxb[0].cyc + s));
         end
         if (rxb.size() > 0) chk("b_ready_rise", 32'(rxb[0].rdy), 32'(1));
         chk("b_end_valid", 32'(if_b.d_valid), 32'(0));
         $display("B vec %0d word=%h samples=%0d", vi, vecs[vi].word, rxb.size());
      end

      // Asynchronous reset in mid-frame with a second word waiting in the hold register.
      txa.push_back(8'h55);
      txa.push_back(8'hAA);
      repeat (5) step();
      #2;
      reset = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(if_a.d_valid),  32'(0));
      chk("mid_rst_dout",  32'(if_a.d_out),    32'(0));
      chk("mid_rst_last",  32'(if_a.d_last),   32'(0));
      chk("mid_rst_ready", 32'(if_a.in_ready), 32'(1));
      chk("mid_rst_busy",  32'(if_a.busy),     32'(0));
      txa.delete();
      @(negedge clk);
      reset = 1'b1;
      rxa.delete();
      repeat (2 * FB + 4) step();
      chk("no_resume", 32'(rxa.size()), 32'(0));
      chk("post_rst_busy", 32'(if_a.busy), 32'(0));
      $display("mid-frame reset: samples after release=%0d", rxa.size());

      stream_a(0, 0, 0, 1, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
